// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RST_PLL,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAULT
    } pll_state_e;

    function automatic int tmr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL RESETB/LOCK sequencer with timeout, retries and lock-loss counting.
// Define PLL_SUP_BYPASS_FALLBACK_EN to run degraded on the bypassed PLL after FAULT.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int RESET_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 4800,
    parameter int STABLE_CYCLES = 480,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 8
) (
    input  logic             clock_in,
    input  logic             resetn,
    input  logic             pll_locked,
    input  logic             relock_req,
    output logic             pll_resetb,
    output logic             pll_bypass,
    output logic             sys_rst_n,
    output logic             ready,
    output logic             fault,
    output logic [CNT_W-1:0] lock_loss_count
);

    localparam int TMR_W = tmr_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int RTY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [TMR_W-1:0] RST_LAST = TMR_W'(RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STB_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    logic lk;

    pll_state_e       state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [RTY_W-1:0] rty_q, rty_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic resetb_q, resetb_d;
    logic srst_q, srst_d;
    logic ready_q, ready_d;
    logic fault_q, fault_d;

    sync_2ff u_lock_sync (
        .clk_i  (clock_in),
        .rst_ni (resetn),
        .d_i    (pll_locked),
        .q_o    (lk)
    );

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rty_d   = rty_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RST_PLL: begin
                if (tmr_q == RST_LAST) state_d = WAIT_LOCK;
                else tmr_d = tmr_q + 1'b1;
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_d = STABLE;
                end else if (tmr_q == TO_LAST) begin
                    rty_d   = rty_q + 1'b1;
                    state_d = (rty_d == RTY_MAX) ? FAULT : RST_PLL;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_d = RST_PLL;
                end else if (tmr_q == STB_LAST) begin
                    state_d = RUN;
                    rty_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            RUN: begin
                if (!lk) begin
                    state_d = RST_PLL;
                    if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                end
            end
            FAULT: ;
            default: state_d = RST_PLL;
        endcase
        // Lock-loss count above survives a simultaneous relock request.
        if (relock_req) begin
            state_d = RST_PLL;
            rty_d   = '0;
        end
        if (state_d != state_q || relock_req) tmr_d = '0;
    end

    assign resetb_d = (state_d == WAIT_LOCK) || (state_d == STABLE) ||
                      (state_d == RUN);
    assign ready_d  = (state_d == RUN);
    assign fault_d  = (state_d == FAULT);

`ifdef PLL_SUP_BYPASS_FALLBACK_EN
    logic arm_q, arm_d;
    logic bypass_q, bypass_d;

    // Release downstream reset on the third FAULT cycle, clocked from bypass.
    assign arm_d    = (state_q == FAULT) && (state_d == FAULT);
    assign bypass_d = (state_d == FAULT);
    assign srst_d   = (state_d == RUN) || ((state_d == FAULT) && arm_q);

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            arm_q    <= 1'b0;
            bypass_q <= 1'b0;
        end else begin
            arm_q    <= arm_d;
            bypass_q <= bypass_d;
        end
    end

    assign pll_bypass = bypass_q;
`else
    assign srst_d     = (state_d == RUN);
    assign pll_bypass = 1'b0;
`endif

    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            state_q  <= RST_PLL;
            tmr_q    <= '0;
            rty_q    <= '0;
            cnt_q    <= '0;
            resetb_q <= 1'b0;
            srst_q   <= 1'b0;
            ready_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            rty_q    <= rty_d;
            cnt_q    <= cnt_d;
            resetb_q <= resetb_d;
            srst_q   <= srst_d;
            ready_q  <= ready_d;
            fault_q  <= fault_d;
        end
    end

    assign pll_resetb      = resetb_q;
    assign sys_rst_n       = srst_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign lock_loss_count = cnt_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor using shortened timing parameters.
module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pll_locked;
    logic       relock_req;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       sys_rst_n;
    logic       ready;
    logic       fault;
    logic [7:0] lock_loss_count;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    pll_lock_supervisor #(
        .RESET_CYCLES  (4),
        .LOCK_TIMEOUT  (64),
        .STABLE_CYCLES (10),
        .MAX_RETRIES   (3),
        .CNT_W         (8)
    ) dut (
        .clock_in        (clk),
        .resetn          (resetn),
        .pll_locked      (pll_locked),
        .relock_req      (relock_req),
        .pll_resetb      (pll_resetb),
        .pll_bypass      (pll_bypass),
        .sys_rst_n       (sys_rst_n),
        .ready           (ready),
        .fault           (fault),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int t);
        while (cyc < t) step1();
    endtask

    task automatic wait_ready(input int bound, input string tag);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < bound) begin
            step1();
            n++;
        end
        check(tag, ready, 1);
    endtask

    initial begin
        resetn     = 1'b0;
        pll_locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) step1();
        check("rst_resetb", pll_resetb, 0);
        check("rst_bypass", pll_bypass, 0);
        check("rst_sysrst", sys_rst_n, 0);
        check("rst_ready", ready, 0);
        check("rst_fault", fault, 0);
        check("rst_count", lock_loss_count, 0);

        // Power-up, lock arrives 50 cycles after RESETB release
        resetn = 1'b1;
        cyc = 0;
        step_to(3);
        check("pu_resetb_low", pll_resetb, 0);
        step_to(4);
        check("pu_resetb_rel", pll_resetb, 1);
        step_to(54);
        pll_locked = 1'b1;
        step_to(66);
        check("pu_sysrst_pre", sys_rst_n, 0);
        check("pu_ready_pre", ready, 0);
        step_to(67);
        check("pu_sysrst", sys_rst_n, 1);
        check("pu_ready", ready, 1);
        check("pu_count", lock_loss_count, 0);

        // One-cycle lock drop in RUN
        step_to(80);
        pll_locked = 1'b0;
        step_to(81);
        pll_locked = 1'b1;
        step_to(82);
        check("loss_sysrst_hold", sys_rst_n, 1);
        step_to(83);
        check("loss_sysrst", sys_rst_n, 0);
        check("loss_ready", ready, 0);
        check("loss_count", lock_loss_count, 1);
        check("loss_resetb", pll_resetb, 0);
        step_to(97);
        check("loss_rerun_pre", ready, 0);
        step_to(98);
        check("loss_rerun", ready, 1);

        // Relock from RUN, then a glitch during STABLE
        step_to(110);
        relock_req = 1'b1;
        step_to(111);
        relock_req = 1'b0;
        check("rl_ready", ready, 0);
        check("rl_resetb", pll_resetb, 0);
        step_to(115);
        check("rl_wait", pll_resetb, 1);
        step_to(118);
        pll_locked = 1'b0;
        step_to(119);
        pll_locked = 1'b1;
        step_to(120);
        check("stb_glitch_hold", pll_resetb, 1);
        step_to(121);
        check("stb_glitch_rst", pll_resetb, 0);
        check("stb_glitch_count", lock_loss_count, 1);
        step_to(135);
        check("stb_rerun_pre", ready, 0);
        step_to(136);
        check("stb_rerun", ready, 1);

        // No lock at all: three timeouts then FAULT
        step_to(150);
        relock_req = 1'b1;
        pll_locked = 1'b0;
        step_to(151);
        relock_req = 1'b0;
        check("to_ready", ready, 0);
        step_to(218);
        check("to1_resetb_hi", pll_resetb, 1);
        step_to(219);
        check("to1_resetb_lo", pll_resetb, 0);
        step_to(223);
        check("to2_resetb_hi", pll_resetb, 1);
        step_to(287);
        check("to2_resetb_lo", pll_resetb, 0);
        step_to(291);
        check("to3_resetb_hi", pll_resetb, 1);
        step_to(354);
        check("to3_fault_pre", fault, 0);
        step_to(355);
        check("fault_set", fault, 1);
        check("fault_resetb", pll_resetb, 0);
        check("fault_ready", ready, 0);
        check("fault_count", lock_loss_count, 1);
`ifdef PLL_SUP_BYPASS_FALLBACK_EN
        check("fb_bypass", pll_bypass, 1);
        step_to(356);
        check("fb_sysrst_pre", sys_rst_n, 0);
        step_to(357);
        check("fb_sysrst", sys_rst_n, 1);
        check("fb_ready", ready, 0);
`else
        check("nofb_bypass", pll_bypass, 0);
        step_to(357);
        check("nofb_sysrst", sys_rst_n, 0);
        step_to(399);
        check("nofb_sysrst_late", sys_rst_n, 0);
`endif
        check("fault_sticky", fault, 1);

        // Relock out of FAULT
        step_to(400);
        relock_req = 1'b1;
        step_to(401);
        relock_req = 1'b0;
        check("rf_fault", fault, 0);
        check("rf_bypass", pll_bypass, 0);
        check("rf_sysrst", sys_rst_n, 0);
        check("rf_ready", ready, 0);
        check("rf_resetb", pll_resetb, 0);
        check("rf_count", lock_loss_count, 1);
        step_to(405);
        check("rf_wait", pll_resetb, 1);

        // Async reset in the middle of WAIT_LOCK
        step_to(410);
        resetn = 1'b0;
        #1;
        check("ar_resetb", pll_resetb, 0);
        check("ar_count", lock_loss_count, 0);
        check("ar_sysrst", sys_rst_n, 0);
        check("ar_fault", fault, 0);
        pll_locked = 1'b1;
        step1();
        step1();
        resetn = 1'b1;
        cyc = 0;
        step_to(4);
        check("ar_rel_resetb", pll_resetb, 1);
        step_to(14);
        check("ar_run_pre", ready, 0);
        step_to(15);
        check("ar_run", ready, 1);
        check("ar_run_sysrst", sys_rst_n, 1);

        // Lock loss coinciding with relock still counts
        step_to(30);
        pll_locked = 1'b0;
        step_to(31);
        pll_locked = 1'b1;
        step_to(32);
        relock_req = 1'b1;
        step_to(33);
        relock_req = 1'b0;
        check("both_count", lock_loss_count, 1);
        check("both_sysrst", sys_rst_n, 0);
        wait_ready(100, "both_rerun");

        // Saturation: 299 more losses
        for (int i = 0; i < 299; i++) begin
            pll_locked = 1'b0;
            step1();
            pll_locked = 1'b1;
            step1();
            step1();
            if (i == 0) check("sat_drop", ready, 0);
            wait_ready(100, "sat_rerun");
            if (i == 252) check("sat_254", lock_loss_count, 254);
            if (i == 253) check("sat_255", lock_loss_count, 255);
        end
        check("sat_final", lock_loss_count, 255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Sequences the iCE40 SB_PLL40_CORE that produces the fast sample clock from the 48 MHz reference. It pulses the PLL's RESETB, waits for LOCK with a timeout, and requires the lock to stay stable before releasing the downstream reset. It also detects loss of lock, retries a bounded number of times, and reports lock-loss counts and a fault flag to the ESP32-facing register block. The block runs entirely in the 48 MHz reference-clock domain; the PLL `locked` output is treated as asynchronous.

## Interface
- RESET_CYCLES, 16: cycles RESETB is held low per attempt (≥1)
- LOCK_TIMEOUT, 4800: cycles allowed for LOCK after RESETB release (100 µs at 48 MHz)
- STABLE_CYCLES, 480: consecutive locked cycles required before release (10 µs)
- MAX_RETRIES, 3: consecutive timeouts tolerated before FAULT
- CNT_W, 8: width of lock-loss counter

Ports:
- clock_in  in  1  48 MHz reference clock
- resetn  in  1  asynchronous, active-low reset
- pll_locked  in  1  PLL LOCK, asynchronous
- relock_req  in  1  single-cycle pulse; forces a full re-sequence
- pll_resetb  out  1  to PLL RESETB; 0 = PLL held in reset
- pll_bypass  out  1  to PLL BYPASS
- sys_rst_n  out  1  downstream reset, active-low, synchronous to clock_in
- ready  out  1  1 only in RUN
- fault  out  1  sticky until relock_req or resetn
- lock_loss_count  out  CNT_W  saturating count of RUN→lock-lost events

## Operation
- `pll_locked` passes through a 2-flop synchronizer to produce `lk`. All decisions use `lk`.
- A single timer `tmr` is sized to clog2(max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES))+1 bits. It is cleared on every state entry.
- A retry counter `retries` is sized to clog2(MAX_RETRIES+1) bits.
- States:
  - RST_PLL: pll_resetb=0, sys_rst_n=0. After RESET_CYCLES cycles → WAIT_LOCK.
  - WAIT_LOCK: pll_resetb=1. If `lk` → STABLE. If tmr reaches LOCK_TIMEOUT-1 without `lk`: retries+1. If the new value is MAX_RETRIES → FAULT; otherwise → RST_PLL.
  - STABLE: if `lk` drops → RST_PLL. There is no retry increment and no loss count here. After STABLE_CYCLES consecutive `lk` cycles → RUN and retries cleared.
  - RUN: sys_rst_n=1, ready=1. If `lk` drops → RST_PLL and lock_loss_count+1, saturating at 2^CNT_W−1.
  - FAULT: fault=1, pll_resetb=0. Behaviour depends on the Configuration macro.
- relock_req in any state → RST_PLL next cycle; retries cleared and fault cleared. lock_loss_count is not cleared.
- If relock_req and lock loss occur in the same RUN cycle, the count still increments.
- Reset (async, any time): state RST_PLL, tmr=0, retries=0, pll_resetb=0, pll_bypass=0, sys_rst_n=0, ready=0, fault=0, lock_loss_count=0.

## Timing
- Synchronizer latency is 2 cycles from a `pll_locked` edge to `lk`.
- All outputs are registered. Each state transition is visible on the outputs 1 cycle after the deciding `lk`/timer condition.
- Minimum power-up to sys_rst_n=1 is RESET_CYCLES + 2 + STABLE_CYCLES + 1 cycles.
- A lock drop in RUN reaches sys_rst_n=0 3 cycles after the `pll_locked` falling edge.
- sys_rst_n deasserts only on a clock_in edge; its assertion is also registered. There is no combinational path from input to output.

## Configuration
- PLL_SUP_BYPASS_FALLBACK_EN defined: FAULT sets pll_bypass=1 and keeps pll_resetb=0. After 2 cycles in FAULT it sets sys_rst_n=1, so the design runs at 48 MHz in degraded mode; ready stays 0 and fault=1.
- Undefined: pll_bypass is tied 0. FAULT holds sys_rst_n=0 until relock_req or resetn.

## Structure
- Package `pll_sup_pkg`: state enum (RST_PLL, WAIT_LOCK, STABLE, RUN, FAULT) and a timer-width function.
- Sub-module `sync_2ff`: the reusable 2-flop synchronizer, with reset to 0 under resetn.

## Test plan
- Power-up with pll_locked rising 50 cycles after RESETB release (RESET_CYCLES=16, STABLE_CYCLES=480) → sys_rst_n and ready rise at cycle 16+50+2+480+1; lock_loss_count=0.
- pll_locked held 0 (MAX_RETRIES=3, LOCK_TIMEOUT=4800) → three RESETB pulses, then fault=1 at the end of the third timeout.
  - Macro on: pll_bypass=1 and sys_rst_n=1 two cycles later.
  - Macro off: sys_rst_n stays 0.
- In RUN, pull pll_locked low for 1 cycle → sys_rst_n=0 3 cycles later, lock_loss_count=1, full re-sequence to RUN.
- A 1-cycle lock glitch during STABLE → back to RST_PLL, lock_loss_count unchanged, retries unchanged.
- Force 300 RUN lock losses with CNT_W=8 → lock_loss_count saturates at 255.
- resetn asserted mid-WAIT_LOCK, and relock_req pulsed in FAULT → both give all outputs at reset values and restart from RST_PLL; relock_req clears fault.
